// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// Results and the divide-by-zero flag are registered and held until the next accepted start.
//
// state | meaning
// IDLE  | waiting for start; previous results held
// RUN   | one restoring step per clock, WIDTH steps total
// DONE  | one-cycle done pulse, then back to IDLE
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] rem_sub;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] quo_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_step;
    logic             fits;

    assign accept    = (state == IDLE) && start;
    assign last_step = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // The borrow out of the subtraction doubles as the r' >= divisor compare.
    assign rem_shift = {rem_r, dvd_r[WIDTH-1]};
    assign rem_sub   = rem_shift - {2'b00, dvs_r};
    assign fits      = ~rem_sub[WIDTH+1];
    assign rem_next  = fits ? rem_sub[WIDTH:0] : rem_shift[WIDTH:0];
    assign quo_next  = {dvd_r[WIDTH-2:0], fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The dividend register shifts left each step; freed LSBs collect quotient bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r       <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            if (accept) begin
                dvd_r       <= dividend;
                dvs_r       <= divisor;
                rem_r       <= '0;
                cnt         <= '0;
                div_by_zero <= (divisor == '0);
            end else if (state == RUN) begin
                rem_r <= rem_next;
                dvd_r <= quo_next;
                cnt   <= cnt + 1'b1;
                if (last_step) begin
                    quotient  <= quo_next;
                    remainder <= rem_next[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned restoring divider: the inverse operation to the team's array multiplier, sharing the same Tiny Tapeout 8-bit pin budget. It accepts a dividend/divisor pair on a start strobe and resolves one quotient bit per clock. It presents the quotient, the remainder and a divide-by-zero flag with a one-cycle done pulse. It sits beside the multiplier behind the project top level; the top-level wrapper multiplexes operands from `ui_in`/`uio_in` and results to `uo_out`.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be at least 2.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request a division; sampled only in IDLE.
- `dividend` input, WIDTH bits: unsigned numerator; sampled on the accepting edge.
- `divisor` input, WIDTH bits: unsigned denominator; sampled on the accepting edge.
- `busy` output, 1 bit: high in the RUN and DONE states.
- `done` output, 1 bit: single-cycle pulse; results are valid from this cycle on.
- `quotient` output, WIDTH bits: registered quotient.
- `remainder` output, WIDTH bits: registered remainder.
- `div_by_zero` output, 1 bit: registered flag, set when the accepted divisor was 0.

## Operation
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `quotient`, `remainder`, `busy`, `done` and `div_by_zero` all go to 0.
  - Internal registers clear: the partial remainder (WIDTH+1 bits), the dividend shift register and the bit counter.
- States and transitions:
  - IDLE → RUN when `start`=1.
  - RUN → RUN while the counter is below WIDTH-1.
  - RUN → DONE on the step where the counter equals WIDTH-1.
  - DONE → IDLE unconditionally.
- On the accepting edge:
  - Latch the operands.
  - Clear the partial remainder and the counter.
  - Set `div_by_zero` to (`divisor`==0).
  - Clear `done`.
  - `quotient` and `remainder` keep their previous values until the final step.
- RUN step (one bit per edge, processed MSB first):
  - Form r' = {r[WIDTH-1:0], next dividend MSB}.
  - If r' ≥ divisor: r ← r' − divisor and shift in a quotient bit of 1.
  - Otherwise: r ← r' and shift in a quotient bit of 0.
  - Counter increments.
- Final RUN step: write the completed quotient and remainder to the output registers.
- DONE: `done`=1 for exactly one cycle.
- Divisor 0 uses no special datapath. The algorithm naturally yields `quotient` = all ones (2^WIDTH−1) and `remainder` = `dividend`, with `div_by_zero`=1. Latency is identical to the normal case.
- Arithmetic is unsigned only. Comparison and subtraction use WIDTH+1 bits so the partial remainder cannot overflow. Invariant: dividend = quotient·divisor + remainder, with remainder < divisor when divisor ≠ 0.
- `start` while busy (RUN or DONE) is ignored; operands are not re-sampled and there is no queuing.
- Results and `div_by_zero` hold until the next accepted start or a reset.

## Timing
- Accepting edge E0 (IDLE, `start`=1): `busy` rises after E0.
- WIDTH RUN steps on edges E1..E_WIDTH.
- `done` is high in the cycle after edge E_WIDTH (for WIDTH=8: after E8) and low again after E_WIDTH+1.
- `busy` falls after edge E_WIDTH+1.
- Start-to-done latency is WIDTH+1 rising edges, counting E0 as the first.
- The earliest next accepting edge is E_WIDTH+2 (`start` held high continuously). Peak throughput is one division per WIDTH+2 cycles.
- `rst` asserted mid-operation aborts immediately:
  - No `done` pulse is produced.
  - Outputs read 0.
  - A `start` on the first edge after `rst` deasserts is accepted normally.
- Outputs are driven from registers only; there are no combinational paths from inputs to outputs.

## Test plan
- 100 ÷ 7, WIDTH=8, `start` pulsed one cycle → `done` after the 9th edge; `quotient`=14, `remainder`=2, `div_by_zero`=0; `busy` high for 9 cycles.
- 255 ÷ 1, then 5 ÷ 9, then 0 ÷ 3 → (255, 0), (0, 5) and (0, 0) respectively; each completes with exactly one `done` pulse.
- 37 ÷ 0 → `quotient`=255, `remainder`=37, `div_by_zero`=1, same 9-edge latency. A following 8 ÷ 2 clears the flag: (4, 0), `div_by_zero`=0.
- Start 200 ÷ 3, then pulse `start` with 9 ÷ 9 on edges E3 and E9 → result is 66 r 2; the second request is ignored and only one `done` pulse occurs.
- Start 50 ÷ 6 and assert `rst` mid-cycle after edge E4 → all outputs 0 immediately. Release `rst` and start 50 ÷ 6 again → `quotient`=8, `remainder`=2 after a full 9 edges.
- Hold `start`=1 continuously with 81 ÷ 9 → operations are accepted every 10 cycles; each gives `quotient`=9, `remainder`=0.
